seq_encoder_8to3: RTL and testbench

- Sequential inverse of the 3-to-8 one-hot decoder.
- Accepts an 8-bit multi-hot request vector over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one per accepted output beat, in priority order.
- Sits between request-collecting logic and any consumer that needs binary indices, such as the select input of the 3-to-8 decoder.

---
 rtl/enc_pkg.sv | 9 +
 rtl/ffs_encoder.sv | 31 +++
 rtl/seq_encoder_8to3.sv | 78 +++++++
 tb/tb_seq_encoder_8to3.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths, state and vector types for the sequential 8-to-3 encoder
package enc_pkg;
    localparam int N_IN  = 8;
    localparam int W_OUT = $clog2(N_IN);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} enc_state_t;
    typedef logic [N_IN-1:0]  req_vec_t;
    typedef logic [W_OUT-1:0] code_t;
endpackage

// File: rtl/ffs_encoder.sv
// rtl/ffs_encoder.sv - combinational find-first-set priority encoder, direction chosen by LSB_FIRST
module ffs_encoder #(
    parameter int N         = 8,
    parameter int W         = $clog2(N),
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] code_o,
    output logic         found_o
);
    // The last match in scan order wins, so scan away from the preferred end.
    always_comb begin
        code_o  = '0;
        found_o = 1'b0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec_i[i]) begin
                    code_o  = W'(i);
                    found_o = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec_i[i]) begin
                    code_o  = W'(i);
                    found_o = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/seq_encoder_8to3.sv
// rtl/seq_encoder_8to3.sv - emits the index of each set bit of an accepted vector, one beat per handshake
module seq_encoder_8to3
    import enc_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  req_vec_t in_vec,
    output logic     out_valid,
    input  logic     out_ready,
    output code_t    out_code,
    output logic     out_last,
    output logic     zero_in,
    output logic     busy
);
    enc_state_t state_q, state_d;
    req_vec_t   pend_q, pend_d;
    logic       zero_q, zero_d;
    code_t      ffs_code;
    logic       ffs_found;
    logic       single_bit;

    ffs_encoder #(
        .N         (N_IN),
        .W         (W_OUT),
        .LSB_FIRST (LSB_FIRST)
    ) u_ffs (
        .vec_i   (pend_q),
        .code_o  (ffs_code),
        .found_o (ffs_found)
    );

    // Clearing the lowest set bit leaves zero exactly when one bit remains.
    assign single_bit = (pend_q & (pend_q - req_vec_t'(1))) == '0;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == EMIT);
    assign out_valid = (state_q == EMIT) && ffs_found;
    assign out_code  = ffs_code;
    assign out_last  = out_valid && single_bit;
    assign zero_in   = zero_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = 1'b0;
        if (state_q == IDLE) begin
            if (in_valid) begin
                if (in_vec != '0) begin
                    pend_d  = in_vec;
                    state_d = EMIT;
                end else begin
                    zero_d = 1'b1;
                end
            end
        end else if (out_valid && out_ready) begin
            pend_d = pend_q & ~(req_vec_t'(1) << ffs_code);
            if (out_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_seq_encoder_8to3.sv
// tb/tb_seq_encoder_8to3.sv - scoreboard bench for both priority directions of seq_encoder_8to3
module tb_seq_encoder_8to3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_vec;
    logic       out_ready;
    logic       in_valid_l, in_valid_m;
    logic       in_ready_l, out_valid_l, out_last_l, zero_in_l, busy_l;
    logic       in_ready_m, out_valid_m, out_last_m, zero_in_m, busy_m;
    logic [2:0] out_code_l, out_code_m;

    typedef struct {
        logic [2:0] code;
        logic       last;
    } beat_t;

    beat_t q_l[$];
    beat_t q_m[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_encoder_8to3 #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_code(out_code_l), .out_last(out_last_l), .zero_in(zero_in_l), .busy(busy_l)
    );

    seq_encoder_8to3 #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_code(out_code_m), .out_last(out_last_m), .zero_in(zero_in_m), .busy(busy_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the vector from the preferred end, one beat per set bit.
    function automatic void model_push(input bit msb, input logic [7:0] v);
        int    n;
        int    seen;
        int    idx;
        beat_t b;
        n    = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) n += v[k] ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            idx = msb ? 7 - k : k;
            if (v[idx]) begin
                seen++;
                b.code = 3'(idx);
                b.last = (seen == n);
                if (msb) q_m.push_back(b);
                else     q_l.push_back(b);
            end
        end
    endfunction

    initial begin
        beat_t      b;
        logic       pv_l;
        logic       pr_l;
        logic [2:0] pc_l;
        logic       pl_l;
        pv_l = 1'b0; pr_l = 1'b0; pc_l = '0; pl_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv_l && !pr_l) begin
                    chk("hold_valid", 32'(out_valid_l), 1);
                    chk("hold_code", 32'(out_code_l), 32'(pc_l));
                    chk("hold_last", 32'(out_last_l), 32'(pl_l));
                end
                if (out_valid_l && out_ready) begin
                    if (q_l.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL lsb_unexpected_beat: got code %0d, expected no beat", out_code_l);
                    end else begin
                        b = q_l.pop_front();
                        chk("lsb_code", 32'(out_code_l), 32'(b.code));
                        chk("lsb_last", 32'(out_last_l), 32'(b.last));
                    end
                end
                if (out_valid_m && out_ready) begin
                    if (q_m.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL msb_unexpected_beat: got code %0d, expected no beat", out_code_m);
                    end else begin
                        b = q_m.pop_front();
                        chk("msb_code", 32'(out_code_m), 32'(b.code));
                        chk("msb_last", 32'(out_last_m), 32'(b.last));
                    end
                end
                pv_l = out_valid_l; pr_l = out_ready; pc_l = out_code_l; pl_l = out_last_l;
            end else begin
                pv_l = 1'b0;
            end
        end
    end

    task automatic wait_ready(input bit msb);
        int t = 0;
        while (!(msb ? in_ready_m : in_ready_l) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_timeout", 32'(t < 100), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_l || busy_m) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", 32'(t < 200), 1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit msb, input logic [7:0] v);
        wait_ready(msb);
        in_vec = v;
        if (msb) in_valid_m = 1'b1;
        else     in_valid_l = 1'b1;
        model_push(msb, v);
        @(posedge clk); #1;
        in_valid_l = 1'b0;
        in_valid_m = 1'b0;
        in_vec     = 8'($urandom);
    endtask

    initial begin
        logic [7:0] v;
        bit         msb;
        int         t;
        rst_n = 1'b0; in_vec = '0; out_ready = 1'b0; in_valid_l = 1'b0; in_valid_m = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready_l), 1);
        chk("rst_out_valid", 32'(out_valid_l), 0);
        chk("rst_busy", 32'(busy_l), 0);
        chk("rst_zero_in", 32'(zero_in_l), 0);
        chk("rst_out_code", 32'(out_code_l), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while stalled in EMIT
        send(1'b0, 8'hFF);
        chk("emit_valid", 32'(out_valid_l), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid_l), 0);
        chk("async_busy", 32'(busy_l), 0);
        chk("async_out_code", 32'(out_code_l), 0);
        chk("async_in_ready", 32'(in_ready_l), 1);
        q_l.delete();
        @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready_l), 1);
        chk("post_rst_out_valid", 32'(out_valid_l), 0);
        @(posedge clk); #1;

        // Basic LSB-first encode, full throughput
        out_ready = 1'b1;
        send(1'b0, 8'b1010_0100);
        chk("basic_beat0", 32'(out_code_l), 2);
        chk("basic_last0", 32'(out_last_l), 0);
        @(posedge clk); #1;
        chk("basic_beat1", 32'(out_code_l), 5);
        @(posedge clk); #1;
        chk("basic_beat2", 32'(out_code_l), 7);
        chk("basic_last2", 32'(out_last_l), 1);
        @(posedge clk); #1;
        chk("basic_in_ready", 32'(in_ready_l), 1);
        chk("basic_done", 32'(out_valid_l), 0);

        // Backpressure holds the first code
        out_ready = 1'b0;
        send(1'b0, 8'h81);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid_l), 1);
            chk("bp_code", 32'(out_code_l), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_code_release", 32'(out_code_l), 0);
        @(posedge clk); #1;
        chk("bp_code_second", 32'(out_code_l), 7);
        chk("bp_last_second", 32'(out_last_l), 1);
        @(posedge clk); #1;

        // All-zero vector: one-cycle pulse, no beat
        send(1'b0, 8'h00);
        chk("zero_pulse", 32'(zero_in_l), 1);
        chk("zero_no_beat", 32'(out_valid_l), 0);
        chk("zero_in_ready", 32'(in_ready_l), 1);
        @(posedge clk); #1;
        chk("zero_pulse_end", 32'(zero_in_l), 0);

        // MSB-first; a new vector offered during EMIT is ignored
        send(1'b1, 8'b0001_0011);
        chk("msb_first", 32'(out_code_m), 4);
        in_vec = 8'hFF; in_valid_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("msb_in_ready_low", 32'(in_ready_m), 0);
            @(posedge clk); #1;
        end
        in_valid_m = 1'b0;
        chk("msb_idle", 32'(busy_m), 0);
        chk("msb_queue_drained", 32'(q_m.size()), 0);
        @(posedge clk); #1;
        chk("msb_stays_idle", 32'(out_valid_m), 0);

        // Reset after the first beat discards the rest
        send(1'b0, 8'hFF);
        chk("abort_first", 32'(out_code_l), 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        q_l.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("abort_no_beat", 32'(out_valid_l), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 8'h08);
        chk("recover_code", 32'(out_code_l), 3);
        chk("recover_last", 32'(out_last_l), 1);
        @(posedge clk); #1;
        chk("recover_idle", 32'(in_ready_l), 1);

        // Randomized vectors with random backpressure on both directions
        for (int n = 0; n < 40; n++) begin
            msb = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            send(msb, v);
            t = 0;
            while ((busy_l || busy_m) && t < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                t++;
            end
            chk("rand_drain_timeout", 32'(t < 100), 1);
        end
        out_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        chk("final_queue_l", 32'(q_l.size()), 0);
        chk("final_queue_m", 32'(q_m.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
